// File: rtl/bloco_defuzzificador.sv
// rtl/bloco_defuzzificador.sv - serial Nie-Tan type-reduction defuzzifier; optional round-half-up via DEFUZ_ROUND_EN
module bloco_defuzzificador #(
    parameter int                   N_RULES = 9,
    parameter int                   W       = 8,
    parameter logic [N_RULES*W-1:0] C_VEC   = {8'd255, 8'd224, 8'd192, 8'd160, 8'd128,
                                               8'd96, 8'd64, 8'd32, 8'd0},
    parameter logic [W-1:0]         DEF_OUT = 8'd128,
    parameter int                   NUM_W   = 21
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   EN_SCLK,
    input  logic                   START,
    input  logic [N_RULES*W-1:0]   FOU_UP_BUS,
    input  logic [N_RULES*W-1:0]   FOU_LOW_BUS,
    output logic [W-1:0]           Saida,
    output logic                   VALID,
    output logic                   BUSY,
    output logic                   ZERO_W
);

    localparam int IDX_W  = $clog2(N_RULES);
    localparam int DEN_W  = W + 1 + IDX_W;
    localparam int REM_W  = W + 5;
    localparam int PROD_W = 2 * W + 1;
    localparam int CNT_W  = $clog2((NUM_W > N_RULES) ? NUM_W : N_RULES);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [N_RULES*W-1:0]   up_q, up_d, low_q, low_d;
    logic [NUM_W-1:0]       num_q, num_d;
    logic [DEN_W-1:0]       den_q, den_d;
    logic [REM_W-1:0]       rem_q, rem_d;
    logic [W-1:0]           saida_q, saida_d;
    logic                   valid_q, valid_d;
    logic                   zero_q, zero_d;

    // Datapath temporaries
    int                     idx;
    logic [W-1:0]           fu, fl, cen;
    logic [W:0]             s;
    logic [PROD_W-1:0]      prod;
    logic [NUM_W-1:0]       num_acc;
    logic [DEN_W-1:0]       den_acc;
    logic [REM_W:0]         trial;
    logic                   qbit;

    // Next-state and datapath: latch, accumulate one rule per cycle, divide one bit per cycle, publish
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        up_d    = up_q;
        low_d   = low_q;
        num_d   = num_q;
        den_d   = den_q;
        rem_d   = rem_q;
        saida_d = saida_q;
        zero_d  = zero_q;
        valid_d = 1'b0;

        idx     = int'(cnt_q);
        fu      = up_q[idx*W +: W];
        fl      = low_q[idx*W +: W];
        cen     = C_VEC[idx*W +: W];
        s       = {1'b0, fu} + {1'b0, fl};
        prod    = PROD_W'(cen) * PROD_W'(s);
        num_acc = num_q + NUM_W'(prod);
        den_acc = den_q + DEN_W'(s);
        trial   = {rem_q, num_q[NUM_W-1]};
        qbit    = (trial >= (REM_W+1)'(den_q));

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    up_d    = FOU_UP_BUS;
                    low_d   = FOU_LOW_BUS;
                    num_d   = '0;
                    den_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                num_d = num_acc;
                den_d = den_acc;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N_RULES - 1)) begin
`ifdef DEFUZ_ROUND_EN
                    // Bias by half the divisor so the truncating divider rounds half-up
                    num_d = num_acc + NUM_W'(den_acc >> 1);
`endif
                    cnt_d   = '0;
                    rem_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                // Dividend bits shift out of num's MSB while quotient bits shift into its LSB
                if (qbit) begin
                    rem_d = trial[REM_W-1:0] - REM_W'(den_q);
                end else begin
                    rem_d = trial[REM_W-1:0];
                end
                num_d = {num_q[NUM_W-2:0], qbit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NUM_W - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                valid_d = 1'b1;
                if (den_q == '0) begin
                    saida_d = DEF_OUT;
                    zero_d  = 1'b1;
                end else begin
                    saida_d = (|num_q[NUM_W-1:W]) ? {W{1'b1}} : num_q[W-1:0];
                    zero_d  = 1'b0;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; everything holds while the clock enable is low
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            up_q    <= '0;
            low_q   <= '0;
            num_q   <= '0;
            den_q   <= '0;
            rem_q   <= '0;
            saida_q <= '0;
            valid_q <= 1'b0;
            zero_q  <= 1'b0;
        end else if (EN_SCLK) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
            low_q   <= low_d;
            num_q   <= num_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            saida_q <= saida_d;
            valid_q <= valid_d;
            zero_q  <= zero_d;
        end
    end

    assign Saida  = saida_q;
    assign VALID  = valid_q;
    assign ZERO_W = zero_q;
    assign BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_bloco_defuzzificador.sv
// tb/tb_bloco_defuzzificador.sv - directed self-checking bench for bloco_defuzzificador
module tb_bloco_defuzzificador;

    logic        clk = 1'b0;
    logic        RESET;
    logic        EN_SCLK;
    logic        START;
    logic [71:0] FOU_UP_BUS;
    logic [71:0] FOU_LOW_BUS;
    logic [7:0]  Saida;
    logic        VALID;
    logic        BUSY;
    logic        ZERO_W;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef DEFUZ_ROUND_EN
    localparam logic [7:0] EXP_EDGES = 8'd128;
`else
    localparam logic [7:0] EXP_EDGES = 8'd127;
`endif

    bloco_defuzzificador dut (
        .clk         (clk),
        .RESET       (RESET),
        .EN_SCLK     (EN_SCLK),
        .START       (START),
        .FOU_UP_BUS  (FOU_UP_BUS),
        .FOU_LOW_BUS (FOU_LOW_BUS),
        .Saida       (Saida),
        .VALID       (VALID),
        .BUSY        (BUSY),
        .ZERO_W      (ZERO_W)
    );

    always #5 clk = ~clk;

    // Mixed pattern: rule 2 fU=200 fL=100, rule 6 fU=100 fL=0 -> 38400/400 = 96
    function automatic logic [71:0] mixed_up();
        logic [71:0] v;
        v = '0;
        v[2*8 +: 8] = 8'd200;
        v[6*8 +: 8] = 8'd100;
        return v;
    endfunction

    function automatic logic [71:0] mixed_low();
        logic [71:0] v;
        v = '0;
        v[2*8 +: 8] = 8'd100;
        return v;
    endfunction

    // Start a job with EN_SCLK high, scramble buses after the latch, wait for VALID
    task automatic run_job(input logic [71:0] up, input logic [71:0] low,
                           output int lat, output logic busy_acc);
        @(negedge clk);
        FOU_UP_BUS  = up;
        FOU_LOW_BUS = low;
        EN_SCLK     = 1'b1;
        START       = 1'b1;
        @(posedge clk); #1;
        busy_acc = BUSY;
        @(negedge clk);
        START       = 1'b0;
        FOU_UP_BUS  = ~up;
        FOU_LOW_BUS = ~low;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (VALID) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0; EN_SCLK = 1'b1; START = 1'b1;
        FOU_UP_BUS = '1; FOU_LOW_BUS = '1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (Saida !== 8'd0)  begin n_fail++; $display("FAIL reset_saida got %0d exp 0", Saida); end
        n_tests++; if (VALID !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b exp 0", VALID); end
        n_tests++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
        n_tests++; if (ZERO_W !== 1'b0) begin n_fail++; $display("FAIL reset_zero_w got %b exp 0", ZERO_W); end
        @(negedge clk);
        START = 1'b0;
        RESET = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL idle_busy got %b exp 0", BUSY); end
    endtask

    task automatic test_zero_weight();
        int lat; logic ba;
        run_job('0, '0, lat, ba);
        n_tests++; if (ba !== 1'b1)     begin n_fail++; $display("FAIL zero_busy_acc got %b exp 1", ba); end
        n_tests++; if (lat != 31)       begin n_fail++; $display("FAIL zero_latency got %0d exp 31", lat); end
        n_tests++; if (Saida !== 8'd128) begin n_fail++; $display("FAIL zero_saida got %0d exp 128", Saida); end
        n_tests++; if (ZERO_W !== 1'b1) begin n_fail++; $display("FAIL zero_flag got %b exp 1", ZERO_W); end
        n_tests++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL zero_busy_done got %b exp 0", BUSY); end
        @(posedge clk); #1;
        n_tests++; if (VALID !== 1'b0)  begin n_fail++; $display("FAIL zero_valid_pulse got %b exp 0", VALID); end
        n_tests++; if (Saida !== 8'd128) begin n_fail++; $display("FAIL zero_saida_hold got %0d exp 128", Saida); end
    endtask

    task automatic test_center();
        int lat; logic ba; logic [71:0] v;
        v = '0;
        v[4*8 +: 8] = 8'd255;
        run_job(v, v, lat, ba);
        n_tests++; if (lat != 31)        begin n_fail++; $display("FAIL center_latency got %0d exp 31", lat); end
        n_tests++; if (Saida !== 8'd128) begin n_fail++; $display("FAIL center_saida got %0d exp 128", Saida); end
        n_tests++; if (ZERO_W !== 1'b0)  begin n_fail++; $display("FAIL center_zero_w got %b exp 0", ZERO_W); end
    endtask

    task automatic test_edges();
        int lat; logic ba; logic [71:0] v;
        v = '0;
        v[0*8 +: 8] = 8'd255;
        v[8*8 +: 8] = 8'd255;
        run_job(v, v, lat, ba);
        n_tests++; if (lat != 31)         begin n_fail++; $display("FAIL edges_latency got %0d exp 31", lat); end
        n_tests++; if (Saida !== EXP_EDGES) begin n_fail++; $display("FAIL edges_saida got %0d exp %0d", Saida, EXP_EDGES); end
        n_tests++; if (ZERO_W !== 1'b0)   begin n_fail++; $display("FAIL edges_zero_w got %b exp 0", ZERO_W); end
    endtask

    task automatic test_back_to_back();
        int lat; logic ba; logic [71:0] v;
        run_job(mixed_up(), mixed_low(), lat, ba);
        n_tests++; if (Saida !== 8'd96)  begin n_fail++; $display("FAIL b2b_mixed_saida got %0d exp 96", Saida); end
        v = '0;
        v[4*8 +: 8] = 8'd255;
        run_job(v, v, lat, ba);
        n_tests++; if (ba !== 1'b1)      begin n_fail++; $display("FAIL b2b_accept got %b exp 1", ba); end
        n_tests++; if (lat != 31)        begin n_fail++; $display("FAIL b2b_latency got %0d exp 31", lat); end
        n_tests++; if (Saida !== 8'd128) begin n_fail++; $display("FAIL b2b_center_saida got %0d exp 128", Saida); end
    endtask

    task automatic test_en_toggle();
        int lat;
        @(negedge clk);
        FOU_UP_BUS  = mixed_up();
        FOU_LOW_BUS = mixed_low();
        EN_SCLK     = 1'b1;
        START       = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            START       = 1'b0;
            EN_SCLK     = ~EN_SCLK;
            FOU_UP_BUS  = {FOU_UP_BUS[70:0], FOU_UP_BUS[71]} ^ 72'h5A;
            FOU_LOW_BUS = ~FOU_LOW_BUS;
            @(posedge clk); #1;
            if (VALID) begin
                lat = n;
                break;
            end
        end
        n_tests++; if (lat != 62)       begin n_fail++; $display("FAIL en_latency got %0d exp 62", lat); end
        n_tests++; if (Saida !== 8'd96) begin n_fail++; $display("FAIL en_saida got %0d exp 96", Saida); end
        @(negedge clk);
        EN_SCLK = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (VALID !== 1'b1)  begin n_fail++; $display("FAIL en_valid_hold got %b exp 1", VALID); end
        @(negedge clk);
        EN_SCLK = 1'b1;
        @(posedge clk); #1;
        n_tests++; if (VALID !== 1'b0)  begin n_fail++; $display("FAIL en_valid_clear got %b exp 0", VALID); end
    endtask

    task automatic test_abort();
        int lat; logic ba; logic saw_valid;
        @(negedge clk);
        FOU_UP_BUS  = mixed_up();
        FOU_LOW_BUS = mixed_low();
        EN_SCLK     = 1'b1;
        START       = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            START = (e == 4);
            @(posedge clk);
        end
        #2;
        n_tests++; if (BUSY !== 1'b1)   begin n_fail++; $display("FAIL abort_busy_pre got %b exp 1", BUSY); end
        RESET = 1'b0;
        #1;
        n_tests++; if (Saida !== 8'd0)  begin n_fail++; $display("FAIL abort_saida got %0d exp 0", Saida); end
        n_tests++; if (BUSY !== 1'b0)   begin n_fail++; $display("FAIL abort_busy got %b exp 0", BUSY); end
        n_tests++; if (VALID !== 1'b0)  begin n_fail++; $display("FAIL abort_valid got %b exp 0", VALID); end
        @(negedge clk);
        START = 1'b0;
        RESET = 1'b1;
        saw_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (VALID) saw_valid = 1'b1;
        end
        n_tests++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid got %b exp 0", saw_valid); end
        run_job(mixed_up(), mixed_low(), lat, ba);
        n_tests++; if (lat != 31)       begin n_fail++; $display("FAIL abort_rerun_latency got %0d exp 31", lat); end
        n_tests++; if (Saida !== 8'd96) begin n_fail++; $display("FAIL abort_rerun_saida got %0d exp 96", Saida); end
    endtask

    initial begin
        test_reset();
        test_zero_weight();
        test_center();
        test_edges();
        test_back_to_back();
        test_en_toggle();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
